mult_acc: RTL and testbench

Sequential accumulator directly downstream of the combinational array multiplier. It consumes a stream of `2*N+2`-bit products over a valid/ready handshake and sums a programmed number of them into a wider accumulator. It presents the final sum with an overflow flag on a second valid/ready handshake. Each product's array settling is absorbed by the registered handshake, so the multiplier output is sampled only on accepted beats.

---
 rtl/mult_acc_pkg.sv | 10 +
 rtl/mult_acc_beat_counter.sv | 20 ++
 rtl/mult_acc.sv | 63 ++++++
 tb/tb_mult_acc.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/mult_acc_pkg.sv
// mult_acc_pkg: state encoding and default width constants for mult_acc
package mult_acc_pkg;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t ACC = 2'd1;
  localparam state_t DONE = 2'd2;
  localparam int DEF_N = 8;
  localparam int DEF_LEN_W = 8;
  localparam int DEF_ACC_W = 2*DEF_N+10;
endpackage

// File: rtl/mult_acc_beat_counter.sv
// beat_counter: loadable down-counter flagging a count of exactly one
module beat_counter
  import mult_acc_pkg::*;
#(
  parameter int W = DEF_LEN_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] d,
  output logic         last
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (load) cnt <= d;
    else if (dec) cnt <= cnt - 1'b1;
  assign last = cnt == W'(1);
endmodule

// File: rtl/mult_acc.sv
// mult_acc: sums a programmed number of products over valid/ready handshakes.
// Define MULT_ACC_SAT_EN to clamp to all ones on overflow instead of wrapping.
module mult_acc
  import mult_acc_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int ACC_W = 2*N+10,
  parameter int LEN_W = DEF_LEN_W,
  localparam int P = 2*N+2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [P-1:0]     prod,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             ovf,
  output logic             busy
);
  state_t state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic [ACC_W:0] sum;
  logic clr, beat, last;
  assign clr = state == IDLE && start;
  assign beat = state == ACC && in_valid;
  assign sum = {1'b0, acc} + (ACC_W+1)'(prod);
  beat_counter #(.W(LEN_W)) u_cnt (
    .clk(clk), .rst(rst), .load(clr), .dec(beat), .d(len), .last(last)
  );
  always_comb begin
    state_nxt = clr ? (len == '0 ? DONE : ACC) :
                (beat && last) ? DONE :
                (state == DONE && out_ready) ? IDLE : state;
`ifdef MULT_ACC_SAT_EN
    acc_nxt = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
    acc_nxt = sum[ACC_W-1:0];
`endif
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      acc <= '0;
      ovf <= 1'b0;
    end else begin
      state <= state_nxt;
      if (clr) begin
        acc <= '0;
        ovf <= 1'b0;
      end else if (beat) begin
        acc <= acc_nxt;
        ovf <= ovf | sum[ACC_W];
      end
    end
  assign in_ready = state == ACC;
  assign out_valid = state == DONE;
  assign busy = in_ready | out_valid;
  assign acc_out = acc;
endmodule

// File: tb/tb_mult_acc.sv
// tb_mult_acc: table, directed and random checks of mult_acc at ACC_W=18 and ACC_W=10
module tb_mult_acc;
  localparam int N = 4;
  localparam int P = 10;
  localparam int LW = 8;
  logic clk = 0, rst = 1, start = 0, in_valid = 0, out_ready = 0;
  logic [LW-1:0] len = 0;
  logic [P-1:0] prod = 0;
  logic in_ready, out_valid, busy, ovf;
  logic in_ready2, out_valid2, busy2, ovf2;
  logic [17:0] acc_out;
  logic [9:0] acc_out2;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  mult_acc #(.N(N), .ACC_W(18), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid), .in_ready(in_ready),
    .prod(prod), .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out), .ovf(ovf), .busy(busy)
  );
  mult_acc #(.N(N), .ACC_W(10), .LEN_W(LW)) dut2 (
    .clk(clk), .rst(rst), .start(start), .len(len), .in_valid(in_valid), .in_ready(in_ready2),
    .prod(prod), .out_valid(out_valid2), .out_ready(out_ready), .acc_out(acc_out2), .ovf(ovf2), .busy(busy2)
  );
  typedef struct {
    int len; int base; int step; int gaps; int bp; int sb; longint exp; bit exp_ovf;
  } vec_t;
  function automatic void model(input longint total, input int w, output longint acc, output bit o);
    longint lim = longint'(1) << w;
    o = total >= lim;
`ifdef MULT_ACC_SAT_EN
    acc = o ? lim - 1 : total;
`else
    acc = total % lim;
`endif
  endfunction
  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask
  task automatic run(input int n, input int vals[$], input int gaps, input int bp, input int sb);
    longint total = 0, e1, e2;
    bit o1, o2;
    start = 1; len = LW'(n);
    @(posedge clk); #1;
    start = 0;
    chk("in_ready_after_start", in_ready, n != 0);
    chk("busy_after_start", busy, 1);
    for (int i = 0; i < n; i++) begin
      if (gaps != 0) repeat ($urandom_range(1, 3)) begin
        in_valid = 0;
        @(posedge clk); #1;
        chk("gap_holds_ready", in_ready, 1);
      end
      chk("no_early_out_valid", out_valid, 0);
      in_valid = 1; prod = P'(vals[i]);
      if (sb != 0) begin start = 1; len = 9; end
      @(posedge clk); #1;
      in_valid = 0; start = 0;
      total += vals[i] & 1023;
    end
    model(total, 18, e1, o1);
    model(total, 10, e2, o2);
    chk("out_valid", out_valid, 1);
    chk("out_valid_w10", out_valid2, 1);
    chk("in_ready_done", in_ready, 0);
    chk("acc_out", acc_out, e1);
    chk("ovf", ovf, o1);
    chk("acc_out_w10", acc_out2, e2);
    chk("ovf_w10", ovf2, o2);
    repeat (bp) begin
      if (sb != 0) begin start = 1; len = 9; end
      @(posedge clk); #1;
      start = 0;
      chk("hold_valid", out_valid, 1);
      chk("hold_acc", acc_out, e1);
      chk("hold_acc_w10", acc_out2, e2);
    end
    out_ready = 1;
    if (sb != 0) begin start = 1; len = 9; end
    @(posedge clk); #1;
    out_ready = 0; start = 0;
    chk("idle_after_ack", {out_valid, busy, in_ready}, 0);
    chk("idle_after_ack_w10", {out_valid2, busy2, in_ready2}, 0);
  endtask
  vec_t tbl[7];
  int q[$];
  initial begin
    tbl[0] = '{3, 225, 0, 0, 0, 0, 675, 0};
    tbl[1] = '{0, 0, 0, 0, 1, 0, 0, 0};
    tbl[2] = '{4, 1, 1, 1, 5, 0, 10, 0};
    tbl[3] = '{5, 225, 0, 0, 0, 0, 1125, 0};
    tbl[4] = '{1, 1023, 0, 0, 2, 0, 1023, 0};
    tbl[5] = '{2, 1023, 0, 1, 3, 1, 2046, 0};
    tbl[6] = '{6, 0, 0, 1, 0, 0, 0, 0};
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_acc", acc_out, 0);
    chk("rst_ovf", ovf, 0);
    @(posedge clk); #1;
    rst = 0;
    foreach (tbl[k]) begin
      q.delete();
      for (int i = 0; i < tbl[k].len; i++) q.push_back((tbl[k].base + tbl[k].step * i) & 1023);
      run(tbl[k].len, q, tbl[k].gaps, tbl[k].bp, tbl[k].sb);
      chk("tbl_acc", acc_out, tbl[k].exp);
      chk("tbl_ovf", ovf, tbl[k].exp_ovf);
    end
    q = '{225, 225, 225, 225, 225};
    run(5, q, 0, 0, 0);
`ifdef MULT_ACC_SAT_EN
    chk("ovf_case_acc_w10", acc_out2, 1023);
`else
    chk("ovf_case_acc_w10", acc_out2, 101);
`endif
    chk("ovf_case_flag_w10", ovf2, 1);
    start = 1; len = 4;
    @(posedge clk); #1;
    start = 0;
    repeat (2) begin
      in_valid = 1; prod = 100;
      @(posedge clk); #1;
    end
    in_valid = 0;
    rst = 1;
    #2;
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_acc", acc_out, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_out_valid", out_valid, 0);
    @(posedge clk); #1;
    rst = 0;
    q = '{7};
    run(1, q, 0, 0, 0);
    chk("rst_recover_acc", acc_out, 7);
    for (int r = 0; r < 40; r++) begin
      int n = $urandom_range(0, 12);
      q.delete();
      for (int i = 0; i < n; i++) q.push_back(int'($urandom_range(0, 1023)));
      run(n, q, $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
